// File: rtl/rsa_mod_inv_if.sv
// rtl/rsa_mod_inv_if.sv - request/result bundle for the iterative modular inverse
interface rsa_mod_inv_if #(
  parameter int WIDTH = 256
);
  logic                 start;
  logic [2*WIDTH-1:0]   a;
  logic [2*WIDTH-1:0]   m;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [2*WIDTH-1:0]   result;

  modport master (output start, a, m, input busy, done, error, result);
  modport slave  (input start, a, m, output busy, done, error, result);
endinterface

// File: rtl/rsa_mod_inv.sv
// rtl/rsa_mod_inv.sv - a^-1 mod m by binary extended Euclid, one step per clock
module rsa_mod_inv #(
  parameter int WIDTH = 256
) (
  input  logic         clk,
  input  logic         reset,
  rsa_mod_inv_if.slave bus
);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CHECK, LOOP, DONE} state_t;

  state_t          state_q, state_d;
  logic [W2-1:0]   u_q, u_d, v_q, v_d;
  logic [W2-1:0]   x1_q, x1_d, x2_q, x2_d;
  logic [W2-1:0]   mod_q, mod_d;
  logic [W2-1:0]   result_q, result_d;
  logic            error_q, error_d;

  // Halving an odd coefficient adds m first; the extra bit keeps the carry.
  logic [W2:0]     x1_plus_m, x2_plus_m;
  logic            illegal;

  assign x1_plus_m = {1'b0, x1_q} + {1'b0, mod_q};
  assign x2_plus_m = {1'b0, x2_q} + {1'b0, mod_q};
  assign illegal   = !mod_q[0] || (mod_q < W2'(3)) || (u_q == '0) || (u_q >= mod_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      u_q      <= '0;
      v_q      <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      mod_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      u_q      <= u_d;
      v_q      <= v_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      mod_q    <= mod_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    v_d      = v_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    mod_d    = mod_q;
    result_d = result_q;
    error_d  = error_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = CHECK;
          u_d      = bus.a;
          v_d      = bus.m;
          x1_d     = W2'(1);
          x2_d     = '0;
          mod_d    = bus.m;
          result_d = '0;
          error_d  = 1'b0;
        end
      end
      CHECK: begin
        if (illegal) begin
          state_d  = DONE;
          error_d  = 1'b1;
          result_d = '0;
        end else begin
          state_d  = LOOP;
        end
      end
      LOOP: begin
        if (u_q == W2'(1)) begin
          state_d  = DONE;
          result_d = x1_q;
          error_d  = 1'b0;
        end else if (v_q == W2'(1)) begin
          state_d  = DONE;
          result_d = x2_q;
          error_d  = 1'b0;
        end else if (u_q == '0 || v_q == '0) begin
          state_d  = DONE;
          result_d = '0;
          error_d  = 1'b1;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_q[0] ? x1_plus_m[W2:1] : (x1_q >> 1);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_q[0] ? x2_plus_m[W2:1] : (x2_q >> 1);
        end else if (u_q >= v_q) begin
          // Wrapping in W2 bits is exact here because the true result lies in [0, m-1].
          u_d  = u_q - v_q;
          x1_d = (x1_q >= x2_q) ? (x1_q - x2_q) : (x1_q + mod_q - x2_q);
        end else begin
          v_d  = v_q - u_q;
          x2_d = (x2_q >= x1_q) ? (x2_q - x1_q) : (x2_q + mod_q - x1_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q == CHECK) || (state_q == LOOP);
  assign bus.done   = (state_q == DONE);
  assign bus.error  = error_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_rsa_mod_inv.sv
// tb/tb_rsa_mod_inv.sv - directed and random-modulus checks for rsa_mod_inv
module tb_rsa_mod_inv;
  localparam int WIDTH = 256;
  localparam int W2    = 2 * WIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rsa_mod_inv_if #(.WIDTH(WIDTH)) bus ();
  rsa_mod_inv #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [W2-1:0] got, input logic [W2-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, inout int lat);
    while (!bus.done && lat < 2200) begin
      tick();
      lat++;
    end
    check({tag, "_done"}, W2'(bus.done), W2'(1));
  endtask

  // lat counts the accept cycle as cycle 0, so an illegal request reports 2.
  task automatic run(input string tag, input logic [W2-1:0] av, input logic [W2-1:0] mv,
                     output logic [W2-1:0] res, output logic err, output int lat);
    bus.a     = av;
    bus.m     = mv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    check({tag, "_busy_after_accept"}, W2'({bus.busy, bus.done}), W2'(2'b10));
    wait_done(tag, lat);
    res = bus.result;
    err = bus.error;
  endtask

  function automatic logic [W2-1:0] rnd_wide();
    logic [W2-1:0] r;
    r = '0;
    for (int i = 0; i < W2 / 32; i++) r = {r[W2-33:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [W2-1:0] gcd(input logic [W2-1:0] x, input logic [W2-1:0] y);
    logic [W2-1:0] t;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  typedef struct {
    string         tag;
    logic [W2-1:0] a;
    logic [W2-1:0] m;
  } ill_t;

  logic [W2-1:0]   res;
  logic            err;
  int              lat;
  logic [W2-1:0]   ra, rm;
  logic [2*W2-1:0] prod;
  ill_t            ill [4];

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.m     = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy",   W2'(bus.busy),  W2'(0));
    check("reset_done",   W2'(bus.done),  W2'(0));
    check("reset_error",  W2'(bus.error), W2'(0));
    check("reset_result", bus.result,     W2'(0));

    run("inv_3_7", W2'(3), W2'(7), res, err, lat);
    check("inv_3_7_err", W2'(err), W2'(0));
    check("inv_3_7_res", res, W2'(5));

    run("inv_53_61", W2'(53), W2'(61), res, err, lat);
    check("inv_53_61_err", W2'(err), W2'(0));
    check("inv_53_61_res", res, W2'(38));
    run("inv_1_61", W2'(1), W2'(61), res, err, lat);
    check("inv_1_61_err", W2'(err), W2'(0));
    check("inv_1_61_res", res, W2'(1));

    run("gcd3", W2'(6), W2'(9), res, err, lat);
    check("gcd3_err", W2'(err), W2'(1));
    check("gcd3_res", res, W2'(0));

    ill[0] = '{"ill_even_m", W2'(5),  W2'(3120)};
    ill[1] = '{"ill_m_one",  W2'(0),  W2'(1)};
    ill[2] = '{"ill_a_zero", W2'(0),  W2'(61)};
    ill[3] = '{"ill_a_ge_m", W2'(61), W2'(53)};
    for (int k = 0; k < 4; k++) begin
      run(ill[k].tag, ill[k].a, ill[k].m, res, err, lat);
      check({ill[k].tag, "_err"}, W2'(err), W2'(1));
      check({ill[k].tag, "_res"}, res, W2'(0));
      check({ill[k].tag, "_lat"}, W2'(lat), W2'(2));
    end

    for (int k = 0; k < 3; k++) begin
      rm = rnd_wide() | W2'(1);
      rm[W2-1] = 1'b1;
      ra = rnd_wide() % rm;
      if (ra == '0) ra = W2'(1);
      run("rnd", ra, rm, res, err, lat);
      check("rnd_lat_bound", W2'(lat <= 8 * WIDTH + 4), W2'(1));
      if (!err) begin
        prod = ({{W2{1'b0}}, res} * {{W2{1'b0}}, ra}) % {{W2{1'b0}}, rm};
        check("rnd_inverse", prod[W2-1:0], W2'(1));
        check("rnd_res_lt_m", W2'(res < rm), W2'(1));
      end else begin
        check("rnd_gcd_not_one", W2'(gcd(ra, rm) != W2'(1)), W2'(1));
      end
    end

    // A second start while busy must not disturb the running inverse.
    bus.a     = W2'(53);
    bus.m     = W2'(61);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.a     = W2'(3);
    bus.m     = W2'(7);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 4;
    wait_done("busy_ignore", lat);
    check("busy_ignore_err", W2'(bus.error), W2'(0));
    check("busy_ignore_res", bus.result, W2'(38));

    bus.a     = W2'(53);
    bus.m     = W2'(61);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy",   W2'(bus.busy),  W2'(0));
    check("abort_done",   W2'(bus.done),  W2'(0));
    check("abort_error",  W2'(bus.error), W2'(0));
    check("abort_result", bus.result,     W2'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
